// File: rtl/cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor
//
// Responder end of the cache's physical-memory port. Each 256-bit line read or
// write from the L1 is carried out as a BEATS-beat burst of BEAT_W-bit words on
// the main-memory bus, and a single-cycle pmem_resp is returned once the whole
// line has moved.
//
// Handshake: a request (pmem_read / pmem_write) is only sampled in IDLE and is
// held by the cache until pmem_resp. On the memory side mem_read / mem_write
// stay high for the whole burst with a fixed mem_address; every cycle with
// mem_resp=1 completes exactly one beat, in ascending beat order, and cycles
// with mem_resp=0 change nothing.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   pmem_address    line address from the cache (low 5 bits ignored)
//   pmem_read       line read request
//   pmem_write      line write request (wins if both are high)
//   pmem_wdata      line to write
//   pmem_rdata      line buffer (assembled read line / last written line)
//   pmem_resp       one-cycle completion pulse
//   mem_address     line-aligned burst base address
//   mem_read        read burst in progress
//   mem_write       write burst in progress
//   mem_wdata       current write beat
//   mem_rdata       current read beat, valid with mem_resp
//   mem_resp        per-beat acknowledge from memory
//   mem_error       sticky beat-timeout flag
//
// Optional feature (macro ADAPTOR_TIMEOUT_EN): a wait counter aborts a burst
// that sees no beat acknowledge for TIMEOUT cycles; the aborted transfer still
// completes with pmem_resp and raises mem_error until reset. Without the macro
// no counter exists, mem_error is tied low and bursts wait indefinitely.
// -----------------------------------------------------------------------------
module cacheline_burst_adaptor #(
    parameter int BEATS   = 4,
    parameter int BEAT_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             pmem_address,
    input  logic                    pmem_read,
    input  logic                    pmem_write,
    input  logic [BEATS*BEAT_W-1:0] pmem_wdata,
    output logic [BEATS*BEAT_W-1:0] pmem_rdata,
    output logic                    pmem_resp,
    output logic [31:0]             mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [BEAT_W-1:0]       mem_wdata,
    input  logic [BEAT_W-1:0]       mem_rdata,
    input  logic                    mem_resp,
    output logic                    mem_error
);

    localparam int               LINE_W     = BEATS * BEAT_W;
    localparam int               CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0]      ALIGN_MASK = ~32'(LINE_W / 8 - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);

    if (BEATS < 2 || TIMEOUT < 2) begin : g_param_check
        $error("cacheline_burst_adaptor: BEATS and TIMEOUT must both be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_k;
    logic [LINE_W-1:0]  r_buf;
    logic [31:0]        r_addr;
    logic               w_last;
    logic               w_timeout;

    assign w_last      = (r_k == LAST_BEAT);
    assign pmem_rdata  = r_buf;
    assign mem_address = r_addr;
    assign mem_wdata   = r_buf[int'(r_k) * BEAT_W +: BEAT_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and bus strobes
    always_comb begin
        w_next    = r_state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (pmem_write) begin
                    w_next = WR_BURST;
                end else if (pmem_read) begin
                    w_next = RD_BURST;
                end
            end
            RD_BURST: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    if (w_last) w_next = DONE;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            WR_BURST: begin
                mem_write = 1'b1;
                if (mem_resp) begin
                    if (w_last) w_next = DONE;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                pmem_resp = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Line buffer, burst address and beat counter. The counter stops at the
    // last beat and only returns to zero through DONE, which also covers an
    // aborted burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k    <= '0;
            r_buf  <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pmem_write) begin
                        r_buf  <= pmem_wdata;
                        r_addr <= pmem_address & ALIGN_MASK;
                    end else if (pmem_read) begin
                        r_addr <= pmem_address & ALIGN_MASK;
                    end
                end
                RD_BURST: begin
                    if (mem_resp) begin
                        r_buf[int'(r_k) * BEAT_W +: BEAT_W] <= mem_rdata;
                        if (!w_last) r_k <= r_k + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (mem_resp && !w_last) r_k <= r_k + 1'b1;
                end
                DONE: begin
                    r_k <= '0;
                end
                default: r_k <= '0;
            endcase
        end
    end

`ifdef ADAPTOR_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] r_wait;
    logic              r_error;

    // r_wait counts the cycles elapsed since the last ack (or burst start),
    // so the value seen in the first cycle after one is 1. Aborting when it
    // reads TIMEOUT-1 puts the pmem_resp pulse exactly TIMEOUT cycles after
    // the last ack.
    assign w_timeout = !mem_resp && (r_wait == WAIT_W'(TIMEOUT - 1));
    assign mem_error = r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait  <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == IDLE || mem_resp) begin
                r_wait <= WAIT_W'(1);
            end else if (r_state == RD_BURST || r_state == WR_BURST) begin
                r_wait <= r_wait + 1'b1;
            end
            if ((r_state == RD_BURST || r_state == WR_BURST) && w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign mem_error = 1'b0;
`endif

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Responder end of the cache's physical-memory interface.
- Accepts 256-bit line reads/writes from the L1 cache datapath/control (pmem_* signals) and performs each as a 4-beat, 64-bit burst on the main-memory bus.
- Returns a single-cycle pmem_resp when the whole line has transferred.
- Sits between the cache and the memory model/arbiter.

Parameters:
- BEATS, 4, beats per line; LINE_W = BEATS*BEAT_W.
- BEAT_W, 64, memory-bus data width in bits.
- TIMEOUT, 255, max cycles waiting for a beat ack before abort (only with ADAPTOR_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pmem_address  in  32  line address from cache; bits [4:0] ignored
- pmem_read  in  1  line read request; held until pmem_resp
- pmem_write  in  1  line write request; held until pmem_resp
- pmem_wdata  in  256  line to write; stable while pmem_write high
- pmem_rdata  out  256  assembled read line; valid when pmem_resp=1 after a read
- pmem_resp  out  1  one-cycle completion pulse
- mem_address  out  32  burst base address, {addr[31:5],5'b0}
- mem_read  out  1  burst read active
- mem_write  out  1  burst write active
- mem_wdata  out  64  current write beat
- mem_rdata  in  64  current read beat; valid when mem_resp=1
- mem_resp  in  1  per-beat ack/valid from memory
- mem_error  out  1  sticky timeout flag; constant 0 without ADAPTOR_TIMEOUT_EN

Behaviour:
- Reset (async, immediate): state=IDLE, beat counter=0, line buffer=0, mem_address=0.
  - mem_read, mem_write, pmem_resp and mem_error go 0 immediately.
  - pmem_rdata reads 0.
  - A burst in flight is abandoned; no pmem_resp is issued for it.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - pmem_write=1: latch pmem_wdata into the buffer and the aligned address; go to WR_BURST.
  - Else pmem_read=1: latch the aligned address; go to RD_BURST.
  - Write has priority if both requests are high.
- RD_BURST:
  - mem_read=1.
  - On each cycle with mem_resp=1, store mem_rdata into buffer[64k+63:64k] (k = beat count) and increment k.
  - When k=BEATS-1 is acked, go to DONE.
  - Cycles without mem_resp hold all state.
- WR_BURST:
  - mem_write=1; mem_wdata = buffer[64k+63:64k].
  - Increment k on mem_resp.
  - Last ack goes to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; mem_read/mem_write=0; k clears to 0.
  - Next state is IDLE.
- Requests are sampled only in IDLE. The cache drops its request the cycle after pmem_resp, so there is no double issue. A request still high in IDLE starts a new transfer (back-to-back allowed, minimum 1 idle cycle between bursts).
- pmem_rdata is the buffer, registered.
  - Holds the last read line until the next transfer starts.
  - After a write completes it holds the written line; the cache ignores it.
- Latency with zero-wait memory (mem_resp tied 1): request seen in IDLE at cycle 0, beats at cycles 1-4, pmem_resp at cycle 5.
- mem_address is constant for the whole burst; beat index is implied by order.
- Counter width is clog2(BEATS); wrap to 0 occurs only through DONE.
- Request inputs changing mid-burst are ignored.

Optional Feature:
- Macro ADAPTOR_TIMEOUT_EN.
- Defined:
  - A wait counter resets on every mem_resp and on burst start.
  - If it reaches TIMEOUT in RD_BURST/WR_BURST, the FSM goes to DONE: pmem_resp pulses, mem_error sets (sticky until rst), and pmem_rdata holds partial beats (unreceived beats keep prior buffer contents).
- Undefined: no counter is built, mem_error is tied 0, and bursts wait indefinitely.

Test Plan:
- Read, zero-wait:
  - Stimulus: pmem_read=1, pmem_address=0x0000_1234; memory returns beats 0x1111..11, 0x2222..22, 0x3333..33, 0x4444..44.
  - Expect: mem_address=0x0000_1220; pmem_resp at cycle 5; pmem_rdata = {0x4444..44,0x3333..33,0x2222..22,0x1111..11}.
- Write with waits:
  - Stimulus: pmem_write=1, pmem_wdata = {64'hD,64'hC,64'hB,64'hA}; mem_resp high every 3rd cycle.
  - Expect: mem_wdata sequence A,B,C,D, each held until acked; pmem_resp exactly once, 1 cycle after 4th ack.
- Simultaneous requests:
  - Stimulus: pmem_read=pmem_write=1.
  - Expect: mem_write=1, mem_read=0; write burst performed first.
- Back-to-back:
  - Stimulus: read completes, then the cache immediately issues a write to 0x40.
  - Expect: one IDLE cycle, then WR_BURST with mem_address=0x40; no spurious second read.
- Reset mid-burst:
  - Stimulus: rst asserted after 2 read beats.
  - Expect: same-cycle mem_read=0, pmem_rdata=0, no pmem_resp.
  - After rst release, a new read completes normally with k starting at 0.
- Timeout (ADAPTOR_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: mem_resp stuck 0 after beat 1.
  - Expect: pmem_resp 8 cycles after the last ack; mem_error=1 and stays 1 until rst.
